mc_controller_hs: RTL and testbench

Parametrised multi-cycle control FSM for the accumulator CPU datapath. It supports multiple accumulators, a two-byte memory/jump instruction format, and one-byte register ALU ops. It adds a memory request/acknowledge handshake with a bounded wait timeout, a HALT instruction and an error exit. It sits beside the datapath and drives every register enable, mux select and ALU op. Its inputs are IR, flags and memory ack.

---
 rtl/mc_ctrl_pkg.sv | 38 +++
 rtl/mc_wait_timer.sv | 35 +++
 rtl/mc_controller_hs.sv | 202 ++++++++++++++++++++
 tb/tb_mc_controller_hs.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle accumulator CPU controller.
// Holds the state encoding, the two-byte opcode groups and the ALU op codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_DECODE,
        S_FETCH2,
        S_RD_OP,
        S_RD_ACC,
        S_EXEC16,
        S_WR_MEM,
        S_JMP,
        S_RD_REGS,
        S_RD_REGS2,
        S_EXEC,
        S_WB
    } state_e;

    // Two-byte format opcode groups live in ir[7:5]
    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_STA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_FETCH2) || (s == S_RD_OP) || (s == S_WR_MEM);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: cleared on state entry or ack, counts stalled cycles.
// expired_o flags the last allowed wait cycle (count == WAIT_LIMIT-1).
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/mc_controller_hs.sv
// Multi-cycle control FSM for the accumulator CPU with a memory req/ack handshake,
// bounded wait timeout (sticky err), HALT and register-format ALU ops.
module mc_controller_hs
    import mc_ctrl_pkg::*;
#(
    parameter int ACC_W      = 2,
    parameter int ALU_OP_W   = 2,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          ir,
    input  logic [2:0]          czn,
    input  logic                mem_ack,
    output logic                done,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_from_tr,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                ir_we,
    output logic                tr_we,
    output logic                a_we,
    output logic                b_we,
    output logic                b_from_mem,
    output logic [ACC_W-1:0]    acc_sel,
    output logic                acc_we,
    output logic                a_zero,
    output logic                b_zero,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_res_we,
    output logic                czn_we
);

    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   mem_st, expired, timeout;
    logic [ACC_W-1:0] dest, src;

    assign mem_st  = is_mem_state(state_q);
    assign timeout = mem_st && !mem_ack && expired;
    assign dest    = ir[ACC_W+1:2];
    assign src     = ir[ACC_W-1:0];
    assign err     = err_q;

    mc_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (8)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!mem_st || mem_ack || expired),
        .inc_i     (mem_st && !mem_ack),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        done         = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_from_tr = 1'b0;
        pc_inc       = 1'b0;
        pc_ld        = 1'b0;
        ir_we        = 1'b0;
        tr_we        = 1'b0;
        a_we         = 1'b0;
        b_we         = 1'b0;
        b_from_mem   = 1'b0;
        acc_sel      = '0;
        acc_we       = 1'b0;
        a_zero       = 1'b0;
        b_zero       = 1'b0;
        alu_op       = ALU_OP_W'(ALU_ADD);
        alu_res_we   = 1'b0;
        czn_we       = 1'b0;

        // Memory states keep req and address select up while stalled; enables only on ack
        case (state_q)
            S_IDLE: begin
                done = 1'b1;
                if (start) state_d = S_START;
            end
            S_START: begin
                if (!start) begin
                    state_d = S_FETCH;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir[7] || ir[7:5] == OP_JMP) state_d = S_FETCH2;
                else if (ir == OP_HALT)          state_d = S_IDLE;
                else if (ir[6])                  state_d = S_FETCH;
                else                             state_d = S_RD_REGS;
            end
            S_FETCH2: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    tr_we  = 1'b1;
                    pc_inc = 1'b1;
                    if (ir[7:5] == OP_JMP)      state_d = S_JMP;
                    else if (ir[7:5] == OP_STA) state_d = S_RD_ACC;
                    else                        state_d = S_RD_OP;
                end
            end
            S_RD_OP: begin
                mem_req      = 1'b1;
                addr_from_tr = 1'b1;
                b_from_mem   = 1'b1;
                if (mem_ack) begin
                    a_we    = 1'b1;
                    b_we    = 1'b1;
                    state_d = S_EXEC16;
                end
            end
            S_RD_ACC: begin
                a_we    = 1'b1;
                b_we    = 1'b1;
                state_d = S_EXEC16;
            end
            S_EXEC16: begin
                alu_res_we = 1'b1;
                case (ir[7:5])
                    OP_LDA: begin a_zero = 1'b1; czn_we = 1'b1; end
                    OP_STA: b_zero = 1'b1;
                    OP_ADD: czn_we = 1'b1;
                    OP_SUB: begin alu_op = ALU_OP_W'(ALU_SUB); czn_we = 1'b1; end
                    default: ;
                endcase
                state_d = (ir[7:5] == OP_STA) ? S_WR_MEM : S_WB;
            end
            S_WR_MEM: begin
                mem_req      = 1'b1;
                addr_from_tr = 1'b1;
                mem_we       = 1'b1;
                if (mem_ack) state_d = S_FETCH;
            end
            S_JMP: begin
                case (ir[2:1])
                    2'b00:   pc_ld = 1'b1;
                    2'b01:   pc_ld = czn[2];
                    2'b10:   pc_ld = czn[1];
                    default: pc_ld = czn[0];
                endcase
                state_d = S_FETCH;
            end
            S_RD_REGS: begin
                acc_sel = src;
                b_we    = 1'b1;
                state_d = S_RD_REGS2;
            end
            S_RD_REGS2: begin
                acc_sel = dest;
                a_we    = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_res_we = 1'b1;
                case (ir[5:4])
                    2'b00:   a_zero = 1'b1;
                    2'b01:   czn_we = 1'b1;
                    2'b10:   begin alu_op = ALU_OP_W'(ALU_SUB); czn_we = 1'b1; end
                    default: begin alu_op = ALU_OP_W'(ALU_AND); czn_we = 1'b1; end
                endcase
                state_d = S_WB;
            end
            S_WB: begin
                acc_we  = 1'b1;
                acc_sel = ir[7] ? dest : '0;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Scoreboard bench: each driven cycle queues its hand-derived output vector,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_mc_controller_hs;

    logic       clk = 1'b0;
    logic       rst, start, mem_ack;
    logic [7:0] ir;
    logic [2:0] czn;
    logic       done, err, mem_req, mem_we, addr_from_tr, pc_inc, pc_ld, ir_we, tr_we;
    logic       a_we, b_we, b_from_mem, acc_we, a_zero, b_zero, alu_res_we, czn_we;
    logic [1:0] acc_sel, alu_op;

    localparam logic [16:0] DONE = 17'h10000, ERR = 17'h08000, MREQ = 17'h04000;
    localparam logic [16:0] MWE  = 17'h02000, AFT = 17'h01000, PCI  = 17'h00800;
    localparam logic [16:0] PCL  = 17'h00400, IRW = 17'h00200, TRW  = 17'h00100;
    localparam logic [16:0] AWE  = 17'h00080, BWE = 17'h00040, BFM  = 17'h00020;
    localparam logic [16:0] ACW  = 17'h00010, AZ  = 17'h00008, BZ   = 17'h00004;
    localparam logic [16:0] ARW  = 17'h00002, CZW = 17'h00001;

    typedef struct {
        logic [16:0] fl;
        logic [1:0]  sel;
        logic [1:0]  op;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [16:0] act_fl;
    assign act_fl = {done, err, mem_req, mem_we, addr_from_tr, pc_inc, pc_ld, ir_we, tr_we,
                     a_we, b_we, b_from_mem, acc_we, a_zero, b_zero, alu_res_we, czn_we};

    always #5 clk = ~clk;

    mc_controller_hs #(
        .ACC_W      (2),
        .ALU_OP_W   (2),
        .WAIT_LIMIT (15)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ir           (ir),
        .czn          (czn),
        .mem_ack      (mem_ack),
        .done         (done),
        .err          (err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_from_tr (addr_from_tr),
        .pc_inc       (pc_inc),
        .pc_ld        (pc_ld),
        .ir_we        (ir_we),
        .tr_we        (tr_we),
        .a_we         (a_we),
        .b_we         (b_we),
        .b_from_mem   (b_from_mem),
        .acc_sel      (acc_sel),
        .acc_we       (acc_we),
        .a_zero       (a_zero),
        .b_zero       (b_zero),
        .alu_op       (alu_op),
        .alu_res_we   (alu_res_we),
        .czn_we       (czn_we)
    );

    // One clock of stimulus: drive ack, queue the expected outputs for this cycle
    task automatic cyc(input logic a, input logic [16:0] fl, input logic [1:0] sel,
                       input logic [1:0] op, input string nm);
        exp_t e;
        mem_ack = a;
        e.fl = fl; e.sel = sel; e.op = op; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic a16(input logic [7:0] i, input logic [16:0] ex_fl, input logic [1:0] op);
        ir = i;
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "a16_fetch");
        cyc(1'b1, 17'h0, 2'd0, 2'd0, "a16_decode");
        cyc(1'b1, MREQ | TRW | PCI, 2'd0, 2'd0, "a16_fetch2");
        cyc(1'b1, MREQ | AFT | BFM | BWE | AWE, 2'd0, 2'd0, "a16_rd_op");
        cyc(1'b1, ex_fl, 2'd0, op, "a16_exec16");
        cyc(1'b1, ACW, 2'd0, 2'd0, "a16_wb");
    endtask

    task automatic jmp(input logic [7:0] i, input logic [2:0] f, input logic taken);
        ir = i; czn = f;
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "jmp_fetch");
        cyc(1'b1, 17'h0, 2'd0, 2'd0, "jmp_decode");
        cyc(1'b1, MREQ | TRW | PCI, 2'd0, 2'd0, "jmp_fetch2");
        cyc(1'b1, taken ? PCL : 17'h0, 2'd0, 2'd0, "jmp_pc_ld");
    endtask

    task automatic rg(input logic [7:0] i, input logic [16:0] ex_fl, input logic [1:0] op,
                      input logic [1:0] src, input logic [1:0] dst);
        ir = i;
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "rg_fetch");
        cyc(1'b1, 17'h0, 2'd0, 2'd0, "rg_decode");
        cyc(1'b1, BWE, src, 2'd0, "rg_rd_regs");
        cyc(1'b1, AWE, dst, 2'd0, "rg_rd_regs2");
        cyc(1'b1, ex_fl, 2'd0, op, "rg_exec");
        cyc(1'b1, ACW, dst, 2'd0, "rg_wb");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({act_fl, acc_sel, alu_op} !== {e.fl, e.sel, e.op}) begin
                    errors++;
                    $display("FAIL %s: got flags=%b acc_sel=%0d alu_op=%0d, want flags=%b acc_sel=%0d alu_op=%0d",
                             e.nm, act_fl, acc_sel, alu_op, e.fl, e.sel, e.op);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; ir = 8'h00; czn = 3'b000;
        @(posedge clk);
        #1;
        cyc(1'b0, DONE, 2'd0, 2'd0, "reset");
        rst = 1'b0;
        cyc(1'b0, DONE, 2'd0, 2'd0, "idle");
        start = 1'b1;
        cyc(1'b0, DONE, 2'd0, 2'd0, "idle_start_hi");
        start = 1'b0;
        cyc(1'b0, 17'h0, 2'd0, 2'd0, "start_lo");

        a16(8'h40, ARW | CZW, 2'd0);

        ir = 8'h20;
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "sta_fetch");
        cyc(1'b1, 17'h0, 2'd0, 2'd0, "sta_decode");
        cyc(1'b1, MREQ | TRW | PCI, 2'd0, 2'd0, "sta_fetch2");
        cyc(1'b1, AWE | BWE, 2'd0, 2'd0, "sta_rd_acc");
        cyc(1'b1, ARW | BZ, 2'd0, 2'd0, "sta_exec16");
        for (int k = 0; k < 3; k++) cyc(1'b0, MREQ | AFT | MWE, 2'd0, 2'd0, "sta_wr_wait");
        cyc(1'b1, MREQ | AFT | MWE, 2'd0, 2'd0, "sta_wr_ack");

        jmp(8'hC4, 3'b010, 1'b1);
        jmp(8'hC4, 3'b000, 1'b0);
        jmp(8'hC4, 3'b101, 1'b0);
        jmp(8'hC2, 3'b100, 1'b1);
        jmp(8'hC6, 3'b110, 1'b0);
        jmp(8'hC0, 3'b000, 1'b1);

        start = 1'b1;
        a16(8'h00, ARW | AZ | CZW, 2'd0);
        start = 1'b0;
        a16(8'h60, ARW | CZW, 2'd1);

        rg(8'hA7, ARW | CZW, 2'd1, 2'd3, 2'd1);
        rg(8'hB6, ARW | CZW, 2'd2, 2'd2, 2'd1);
        rg(8'h84, ARW | AZ, 2'd0, 2'd0, 2'd1);
        rg(8'h9C, ARW | CZW, 2'd0, 2'd0, 2'd3);

        ir = 8'hE0;
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "nop_fetch");
        cyc(1'b1, 17'h0, 2'd0, 2'd0, "nop_decode");

        for (int k = 0; k < 14; k++) cyc(1'b0, MREQ, 2'd0, 2'd0, "tmo_wait");
        cyc(1'b0, MREQ, 2'd0, 2'd0, "tmo_last");
        cyc(1'b0, DONE | ERR, 2'd0, 2'd0, "tmo_idle");
        start = 1'b1;
        cyc(1'b0, DONE | ERR, 2'd0, 2'd0, "tmo_idle_start");
        start = 1'b0;
        cyc(1'b0, ERR, 2'd0, 2'd0, "tmo_start_lo");
        for (int k = 0; k < 14; k++) cyc(1'b0, MREQ, 2'd0, 2'd0, "lim_wait");
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "ack_at_limit");
        ir = 8'hFF;
        cyc(1'b0, 17'h0, 2'd0, 2'd0, "halt_decode");
        cyc(1'b0, DONE, 2'd0, 2'd0, "halt_idle");
        cyc(1'b0, DONE, 2'd0, 2'd0, "halt_stays");

        start = 1'b1;
        cyc(1'b0, DONE, 2'd0, 2'd0, "rs_idle_start");
        start = 1'b0;
        cyc(1'b0, 17'h0, 2'd0, 2'd0, "rs_start_lo");
        ir = 8'h40;
        cyc(1'b1, MREQ | IRW | PCI, 2'd0, 2'd0, "rs_fetch");
        cyc(1'b1, 17'h0, 2'd0, 2'd0, "rs_decode");
        cyc(1'b1, MREQ | TRW | PCI, 2'd0, 2'd0, "rs_fetch2");
        cyc(1'b1, MREQ | AFT | BFM | BWE | AWE, 2'd0, 2'd0, "rs_rd_op");
        rst = 1'b1;
        cyc(1'b1, DONE, 2'd0, 2'd0, "rst_in_exec16");
        rst = 1'b0;
        cyc(1'b1, DONE, 2'd0, 2'd0, "rst_then_idle");

        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
